// File: rtl/servo_pkg.sv
// Shared constants and types for the pan/tilt servo request scheduler.
// Holds the default position geometry, requester count and priority helpers.
package servo_pkg;

  localparam int DEF_POS_W  = 8;
  localparam int DEF_CENTER = 128;
  localparam int N_REQ      = 3;

  typedef logic [1:0]       req_idx_t;
  typedef logic [N_REQ-1:0] grant_oh_t;

  // Lowest asserted index wins; callers qualify the result with |vld.
  function automatic req_idx_t pick_winner(input logic [N_REQ-1:0] vld);
    req_idx_t idx;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (vld[i]) idx = req_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic grant_oh_t idx_to_onehot(input req_idx_t idx);
    return grant_oh_t'(1) << idx;
  endfunction

endpackage

// File: rtl/servo_axis_channel.sv
// One servo axis: current/target position, bounded slew per frame, and the
// PWM pulse whose width is latched from the post-step position at each frame edge.
module servo_axis_channel #(
  parameter int FRAME_CYC = 2_000_000,
  parameter int MIN_CYC   = 100_000,
  parameter int STEP_CYC  = 392,
  parameter int POS_W     = 8,
  parameter int CENTER    = 128,
  parameter int SLEW      = 4,
  parameter int CNT_W     = $clog2(FRAME_CYC)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_frame_edge,
  input  logic             i_step_en,
  input  logic             i_load_tgt,
  input  logic [POS_W-1:0] i_new_tgt,
  output logic [POS_W-1:0] o_cur_nxt,
  output logic [POS_W-1:0] o_tgt_nxt,
  output logic             o_pulse
);

  localparam logic signed [POS_W:0] SLEW_P = (POS_W+1)'(SLEW);
  localparam logic signed [POS_W:0] SLEW_N = -SLEW_P;

  logic [POS_W-1:0]      r_cur;
  logic [POS_W-1:0]      r_tgt;
  logic [CNT_W-1:0]      r_left;
  logic                  r_pulse;
  logic signed [POS_W:0] w_diff;
  logic [POS_W-1:0]      w_stepped;
  logic [CNT_W-1:0]      w_width;

  // Extra sign bit keeps the difference exact, so the step can never wrap.
  always_comb begin
    w_diff = $signed({1'b0, r_tgt}) - $signed({1'b0, r_cur});
    if (w_diff > SLEW_P) begin
      w_stepped = r_cur + POS_W'(SLEW);
    end else if (w_diff < SLEW_N) begin
      w_stepped = r_cur - POS_W'(SLEW);
    end else begin
      w_stepped = r_tgt;
    end
  end

  always_comb begin
    o_cur_nxt = r_cur;
    o_tgt_nxt = r_tgt;
    if (i_frame_edge && i_step_en) begin
      o_cur_nxt = w_stepped;
      if (i_load_tgt) begin
        o_tgt_nxt = i_new_tgt;
      end
    end
  end

  assign w_width = CNT_W'(MIN_CYC) + CNT_W'(o_cur_nxt) * CNT_W'(STEP_CYC);

  // Pulse rises on the frame edge; the down-counter drops it after w_width cycles.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cur   <= POS_W'(CENTER);
      r_tgt   <= POS_W'(CENTER);
      r_left  <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_cur <= o_cur_nxt;
      r_tgt <= o_tgt_nxt;
      if (i_frame_edge) begin
        r_pulse <= 1'b1;
        r_left  <= w_width - CNT_W'(1);
      end else if (r_pulse) begin
        if (r_left == '0) begin
          r_pulse <= 1'b0;
        end else begin
          r_left <= r_left - CNT_W'(1);
        end
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/servo_request_scheduler.sv
// Single owner of the pan/tilt servo PWM outputs: frames time, arbitrates
// requesters once per frame under fixed priority, and drives both axis channels.
module servo_request_scheduler
  import servo_pkg::*;
#(
  parameter int FRAME_CYC = 2_000_000,
  parameter int MIN_CYC   = 100_000,
  parameter int STEP_CYC  = 392,
  parameter int POS_W     = DEF_POS_W,
  parameter int CENTER    = DEF_CENTER,
  parameter int SLEW      = 4
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*POS_W-1:0] req_x,
  input  logic [N_REQ*POS_W-1:0] req_y,
  input  logic                   hold,
  output logic [N_REQ-1:0]       req_ack,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic                   frame_tick,
  output logic                   Pulse_X,
  output logic                   Pulse_Y
);

  localparam int               CNT_W    = $clog2(FRAME_CYC);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYC - 1);

  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_tick;
  logic [N_REQ-1:0] r_ack;
  logic [N_REQ-1:0] r_grant;
  logic             r_busy;

  logic             w_frame_edge;
  logic             w_accept;
  req_idx_t         w_win;
  grant_oh_t        w_win_oh;
  logic [POS_W-1:0] w_new_x;
  logic [POS_W-1:0] w_new_y;
  logic [POS_W-1:0] w_cur_x;
  logic [POS_W-1:0] w_tgt_x;
  logic [POS_W-1:0] w_cur_y;
  logic [POS_W-1:0] w_tgt_y;
  logic             w_pulse_x;
  logic             w_pulse_y;

  assign w_frame_edge = (r_frame_cnt == LAST_CNT);
  assign w_win        = pick_winner(req_vld);
  assign w_win_oh     = idx_to_onehot(w_win);
  assign w_accept     = w_frame_edge && !hold && (|req_vld);
  assign w_new_x      = req_x[int'(w_win) * POS_W +: POS_W];
  assign w_new_y      = req_y[int'(w_win) * POS_W +: POS_W];

  servo_axis_channel #(
    .FRAME_CYC (FRAME_CYC),
    .MIN_CYC   (MIN_CYC),
    .STEP_CYC  (STEP_CYC),
    .POS_W     (POS_W),
    .CENTER    (CENTER),
    .SLEW      (SLEW),
    .CNT_W     (CNT_W)
  ) u_axis_x (
    .i_clk        (sysclk),
    .i_rst_n      (reset),
    .i_frame_edge (w_frame_edge),
    .i_step_en    (!hold),
    .i_load_tgt   (w_accept),
    .i_new_tgt    (w_new_x),
    .o_cur_nxt    (w_cur_x),
    .o_tgt_nxt    (w_tgt_x),
    .o_pulse      (w_pulse_x)
  );

  servo_axis_channel #(
    .FRAME_CYC (FRAME_CYC),
    .MIN_CYC   (MIN_CYC),
    .STEP_CYC  (STEP_CYC),
    .POS_W     (POS_W),
    .CENTER    (CENTER),
    .SLEW      (SLEW),
    .CNT_W     (CNT_W)
  ) u_axis_y (
    .i_clk        (sysclk),
    .i_rst_n      (reset),
    .i_frame_edge (w_frame_edge),
    .i_step_en    (!hold),
    .i_load_tgt   (w_accept),
    .i_new_tgt    (w_new_y),
    .o_cur_nxt    (w_cur_y),
    .o_tgt_nxt    (w_tgt_y),
    .o_pulse      (w_pulse_y)
  );

  // busy follows the channels' next-state values so it settles on the same edge.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_frame_cnt <= LAST_CNT;
      r_tick      <= 1'b0;
      r_ack       <= '0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_cnt <= w_frame_edge ? '0 : r_frame_cnt + CNT_W'(1);
      r_tick      <= w_frame_edge;
      r_ack       <= w_accept ? w_win_oh : '0;
      if (w_accept) begin
        r_grant <= w_win_oh;
      end
      r_busy <= (w_cur_x != w_tgt_x) || (w_cur_y != w_tgt_y);
    end
  end

  assign req_ack    = r_ack;
  assign grant      = r_grant;
  assign busy       = r_busy;
  assign frame_tick = r_tick;
  assign Pulse_X    = w_pulse_x;
  assign Pulse_Y    = w_pulse_y;

endmodule
